prbs7_sync_checker: RTL and testbench
=====================================

Name: prbs7_sync_checker

Overview:
- Receive-side counterpart of the team's 7-bit XNOR LFSR pattern generator.
- Consumes the generator's serial stream (its last stage, y6) one bit per qualified cycle.
- Self-synchronises to the PRBS-7 sequence, then flags and counts bit errors.
- Drops lock after excessive errors in a window.
- Used for link/BIST checking of the cache-side test datapaths.

Parameters:
- LOCK_COUNT, 14: consecutive correct predictions required to declare lock.
- WINDOW, 127: valid-bit length of the loss-of-lock observation window.
- ERR_THRESH, 8: errors within one window that force loss of lock.
- ERR_CNT_W, 16: width of the cumulative error counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_valid  in  1  qualifies data_in this cycle; all state holds when low.
- data_in  in  1  received serial PRBS bit.
- clear_count  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED state.
- error  out  1  one-cycle pulse: mismatch on the previous valid bit while locked.
- lost_lock  out  1  one-cycle pulse on the LOCKED->SEEK transition.
- err_count  out  ERR_CNT_W  cumulative errors while locked; saturating.

Behaviour:
- Reset (async, active-high):
  - history h[6:0]=0, state=SEEK, fill/match/window counters=0.
  - locked=0, error=0, lost_lock=0, err_count=0.
- Sequence law: h[0] is the newest bit, h[6] the oldest. Prediction p = h[6] XNOR h[5]. This is equivalent to b[n] = b[n-7] XNOR b[n-6].
- Cycles without data_valid: no state changes; error and lost_lock are 0.
- SEEK:
  - Each valid bit: h <= {h[5:0], data_in}.
  - Fill counter counts to 7; no prediction is checked before 7 bits are loaded.
  - After fill: data_in==p increments the match counter; data_in!=p zeroes it.
  - If h==7'h7F (XNOR lockup pattern), the match counter is held at 0, so an all-ones stream never locks.
  - When the match counter reaches LOCK_COUNT: state<=LOCKED and locked=1 from the next cycle. Window counter and window-error counter are zeroed.
  - error is never asserted in SEEK.
- LOCKED:
  - Each valid bit: h <= {h[5:0], p}. The local generator free-runs, so received errors do not corrupt the reference.
  - Mismatch (data_in!=p): error pulses the next cycle, err_count increments (saturates at all-ones), and the window-error counter increments.
  - The window counter counts valid bits 0..WINDOW-1. On wrap, the window-error counter is cleared; an error on the wrap bit counts toward the new window.
  - When the window-error counter reaches ERR_THRESH:
    - state<=SEEK, with lost_lock and locked=0 registered in the same cycle.
    - Fill, match and window counters are zeroed.
    - h is retained but refilled before use.
- Latency: all outputs are registered, one cycle after the qualifying valid bit.
- clear_count: err_count<=0 next cycle. clear_count has priority over a simultaneous increment (result is 0). It does not affect lock state or window counters.
- Reset mid-stream: returns immediately to the reset values; relock requires 7+LOCK_COUNT valid bits.

Decomposition:
- Shared package prbs_pkg holds:
  - the state enum {SEEK, LOCKED};
  - PRBS7_LEN=7 and tap indices 6,5;
  - XNOR_LOCKUP=7'h7F.
- One natural sub-module, sat_counter (width parameter; inc, clr with priority, saturate at max). It is used for err_count and the window-error count.

Test Plan:
- Clean stream from the team's 7-bit XNOR generator (seed bit4=1, enable=1), serial y6 -> locked rises on the cycle after the 21st valid bit; err_count stays 0 over 1000 bits; error never pulses.
- Locked, one bit inverted at bit 100 -> single error pulse one cycle later; err_count=1; locked stays 1; following bits produce no error (no propagation).
- Locked, 8 inverted bits within 127 bits -> on the 8th, lost_lock pulses and locked=0; a clean stream afterwards relocks after 21 more valid bits.
- Locked, 7 errors per window at window positions 0..6 repeated over 3 windows -> lock held; err_count=21.
- Constant data_in=1 for 200 valid bits after reset -> never locks; err_count=0. Then data_valid low for 50 cycles mid-stream -> counters frozen, no pulses.
- err_count driven to 16'hFFFF by forcing errors (hold locked, ERR_THRESH raised) -> stays at 16'hFFFF. clear_count asserted in the same cycle as an error -> err_count=0. Async reset asserted mid-lock -> locked=0 immediately.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-7 (XNOR form) constants, lock states and predictor.
package prbs_pkg;
  typedef enum logic {SEEK, LOCKED} state_e;
  localparam int PRBS7_LEN = 7;
  localparam int TAP_A = 6;
  localparam int TAP_B = 5;
  localparam logic [6:0] XNOR_LOCKUP = 7'h7F;
  function automatic logic prbs7_predict(input logic [6:0] h);
    return ~(h[TAP_A] ^ h[TAP_B]);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with priority clear.
// With CLR_INC set, a clear in the same cycle as an increment restarts at 1.
module sat_counter #(
  parameter int W = 8,
  parameter bit CLR_INC = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? W'(CLR_INC & inc_i) : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/prbs7_sync_checker.sv
// prbs7_sync_checker: self-synchronising PRBS-7 receiver with error counting
// and window-based loss of lock.
module prbs7_sync_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 14,
  parameter int WINDOW = 127,
  parameter int ERR_THRESH = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 data_valid,
  input  logic                 data_in,
  input  logic                 clear_count,
  output logic                 locked,
  output logic                 error,
  output logic                 lost_lock,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  state_e        state_q, state_d;
  logic [6:0]    h_q, h_d;
  logic [2:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] win_q, win_d;
  logic          error_q, error_d, lost_q, lost_d;
  logic          p, mism, wrap, err_inc, werr_inc, werr_clr;
  logic [EW-1:0] werr, werr_next;
  assign p = prbs7_predict(h_q);
  assign mism = data_in != p;
  assign wrap = win_q == WW'(WINDOW - 1);
  // errors on the wrap bit belong to the window that starts after it
  assign werr_next = (wrap ? '0 : werr) + EW'(mism);
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    fill_d = fill_q;
    match_d = match_q;
    win_d = win_q;
    error_d = 1'b0;
    lost_d = 1'b0;
    err_inc = 1'b0;
    werr_inc = 1'b0;
    werr_clr = 1'b0;
    if (data_valid) begin
      if (state_q == SEEK) begin
        h_d = {h_q[5:0], data_in};
        if (fill_q != 3'(PRBS7_LEN)) fill_d = fill_q + 3'd1;
        else if (h_q == XNOR_LOCKUP || mism) match_d = '0;
        else if (match_q == MW'(LOCK_COUNT - 1)) begin
          state_d = LOCKED;
          match_d = '0;
          win_d = '0;
          werr_clr = 1'b1;
        end else match_d = match_q + MW'(1);
      end else begin
        // free-running reference: received errors never enter the history
        h_d = {h_q[5:0], p};
        error_d = mism;
        err_inc = mism;
        werr_inc = mism;
        werr_clr = wrap;
        win_d = wrap ? '0 : win_q + WW'(1);
        if (werr_next == EW'(ERR_THRESH)) begin
          state_d = SEEK;
          lost_d = 1'b1;
          fill_d = '0;
          match_d = '0;
          win_d = '0;
        end
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= SEEK;
      h_q <= '0;
      fill_q <= '0;
      match_q <= '0;
      win_q <= '0;
      error_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      fill_q <= fill_d;
      match_q <= match_d;
      win_q <= win_d;
      error_q <= error_d;
      lost_q <= lost_d;
    end
  sat_counter #(.W(EW), .CLR_INC(1'b1)) u_werr (
    .clk_i(clock), .rst_i(reset), .inc_i(werr_inc), .clr_i(werr_clr), .cnt_o(werr)
  );
  sat_counter #(.W(ERR_CNT_W), .CLR_INC(1'b0)) u_errcnt (
    .clk_i(clock), .rst_i(reset), .inc_i(err_inc), .clr_i(clear_count), .cnt_o(err_count)
  );
  assign locked = state_q == LOCKED;
  assign error = error_q;
  assign lost_lock = lost_q;
endmodule

// File: tb/tb_prbs7_sync_checker.sv
// tb_prbs7_sync_checker: randomized and directed checks of prbs7_sync_checker
// against a sequence-level reference model.
module tb_prbs7_sync_checker;
  localparam int LOCK_COUNT = 14, WINDOW = 127, ERR_THRESH = 8;
  logic clock = 0, reset = 1, data_valid = 0, data_in = 0, clear_count = 0;
  logic locked, error, lost_lock;
  logic [15:0] err_count;
  logic s_valid = 0, s_din = 0, s_clr = 0, s_locked, s_error, s_lost;
  logic [7:0] s_cnt;
  int n_cmp = 0, n_err = 0;
  int error_seen = 0, lost_seen = 0;
  bit gw[$] = '{0, 0, 1, 0, 0, 0, 0};
  bit mq[$];
  bit m_locked, exp_err, exp_lost;
  int m_fill, m_match, m_k, m_wid, m_werr, m_cnt;

  prbs7_sync_checker dut (
    .clock(clock), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .clear_count(clear_count), .locked(locked), .error(error),
    .lost_lock(lost_lock), .err_count(err_count)
  );
  prbs7_sync_checker #(.ERR_THRESH(200), .ERR_CNT_W(8)) sat_dut (
    .clock(clock), .reset(reset), .data_valid(s_valid), .data_in(s_din),
    .clear_count(s_clr), .locked(s_locked), .error(s_error),
    .lost_lock(s_lost), .err_count(s_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference generator: b[n] = b[n-7] XNOR b[n-6], seed bit4 of y = 1
  function automatic bit gen();
    bit b = gw[0];
    gw.push_back(!(gw[0] ^ gw[1]));
    void'(gw.pop_front());
    return b;
  endfunction

  function automatic void model_reset();
    mq = '{0, 0, 0, 0, 0, 0, 0};
    m_locked = 0; m_fill = 0; m_match = 0; m_cnt = 0; m_k = 0; m_wid = 0; m_werr = 0;
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit c);
    bit p, all1;
    exp_err = 0; exp_lost = 0;
    if (v) begin
      p = !(mq[0] ^ mq[1]);
      if (!m_locked) begin
        all1 = 1;
        foreach (mq[i]) all1 &= mq[i];
        if (m_fill < 7) m_fill++;
        else m_match = (all1 || d != p) ? 0 : m_match + 1;
        mq.push_back(d);
        void'(mq.pop_front());
        if (m_match == LOCK_COUNT) begin
          m_locked = 1; m_match = 0; m_k = 0; m_wid = 0; m_werr = 0;
        end
      end else begin
        mq.push_back(p);
        void'(mq.pop_front());
        if ((m_k + 1) / WINDOW != m_wid) begin
          m_wid = (m_k + 1) / WINDOW;
          m_werr = 0;
        end
        if (d != p) begin
          exp_err = 1;
          m_werr++;
          if (m_cnt < 65535) m_cnt++;
        end
        m_k++;
        if (m_werr == ERR_THRESH) begin
          m_locked = 0; m_fill = 0; m_match = 0; exp_lost = 1;
        end
      end
    end
    if (c) m_cnt = 0;
  endfunction

  task automatic step(input bit v, input bit d, input bit c);
    @(negedge clock);
    data_valid = v; data_in = d; clear_count = c;
    @(posedge clock);
    #1;
    model_step(v, d, c);
    chk("locked", locked, m_locked);
    chk("error", error, exp_err);
    chk("lost_lock", lost_lock, exp_lost);
    chk("err_count", err_count, m_cnt);
    error_seen += int'(error);
    lost_seen += int'(lost_lock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; data_valid = 0; clear_count = 0; s_valid = 0; s_clr = 0;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_lost", lost_lock, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic run_to_lock(input string tag, output int n);
    n = 0;
    while (!locked && n < 200) begin
      step(1, gen(), 0);
      n++;
    end
    chk({tag, "_lock_bits"}, n, 21);
  endtask

  task automatic sstep(input bit v, input bit d, input bit c);
    @(negedge clock);
    s_valid = v; s_din = d; s_clr = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n, e0, l0, ones_lock;
    model_reset();
    do_reset();
    // clean stream: lock after 21 bits, no errors over 1000 bits
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, gen(), 0);
      if (locked && n == 0) n = i + 1;
    end
    chk("clean_lock_bits", n, 21);
    chk("clean_errors", error_seen, 0);
    chk("clean_err_count", err_count, 0);
    // single inverted bit
    e0 = error_seen;
    for (int j = 0; j < 150; j++) step(1, gen() ^ (j == 100), 0);
    chk("single_pulses", error_seen - e0, 1);
    chk("single_err_count", err_count, 1);
    chk("single_locked", locked, 1);
    // eight errors inside one window -> loss of lock, then relock
    for (int i = 0; i < 200 && m_k % WINDOW != 5; i++) step(1, gen(), 0);
    l0 = lost_seen;
    for (int e = 0; e < 8; e++) begin
      for (int g = $urandom_range(1, 10); g > 0; g--) step(1, gen(), 0);
      step(1, !gen(), 0);
    end
    chk("burst_lost", lost_seen - l0, 1);
    chk("burst_locked", locked, 0);
    run_to_lock("relock", n);
    // seven errors at window positions 0..6 over three windows
    do_reset();
    run_to_lock("win", n);
    l0 = lost_seen;
    for (int i = 0; i < 3 * WINDOW; i++) step(1, gen() ^ (m_k % WINDOW < 7), 0);
    chk("win_err_count", err_count, 21);
    chk("win_locked", locked, 1);
    chk("win_lost", lost_seen - l0, 0);
    // all-ones never locks; idle cycles freeze everything
    do_reset();
    ones_lock = 0;
    for (int i = 0; i < 200; i++) begin
      step(1, 1, 0);
      ones_lock += int'(locked);
    end
    e0 = error_seen; l0 = lost_seen;
    for (int i = 0; i < 50; i++) step(0, 1'($urandom), 0);
    for (int i = 0; i < 50; i++) step(1, 1, 0);
    chk("ones_lock_cycles", ones_lock, 0);
    chk("ones_err_count", err_count, 0);
    chk("idle_pulses", error_seen - e0 + lost_seen - l0, 0);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, gen() ^ ($urandom_range(0, 39) == 0), $urandom_range(0, 99) == 0);
    // clear_count wins over a simultaneous error
    for (int i = 0; i < 300 && !locked; i++) step(1, gen(), 0);
    step(1, !gen(), 0);
    step(1, !gen(), 1);
    chk("clr_pulse", error, 1);
    chk("clr_priority", err_count, 0);
    // asynchronous reset mid-lock
    for (int i = 0; i < 300 && !locked; i++) step(1, gen(), 0);
    chk("pre_async_locked", locked, 1);
    #2 reset = 1;
    #1 chk("async_locked", locked, 0);
    @(negedge clock) reset = 0;
    model_reset();
    run_to_lock("post_async", n);
    // saturation on an 8-bit counter instance
    @(negedge clock) data_valid = 0;
    n = 0;
    while (!s_locked && n < 200) begin
      sstep(1, gen(), 0);
      n++;
    end
    chk("sat_lock_bits", n, 21);
    for (int i = 0; i < 300; i++) sstep(1, !gen(), 0);
    chk("sat_value", s_cnt, 255);
    chk("sat_locked", s_locked, 1);
    sstep(1, !gen(), 1);
    chk("sat_clr", s_cnt, 0);
    sstep(1, !gen(), 0);
    chk("sat_after_clr", s_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
